// File: rtl/alu_fu_array.sv
// NUM_FU independent integer ALU pipelines (LAT stages, in-order, 1 op/cycle/FU) with tagged writeback.
// A held result (wb_valid && !wb_ready) freezes that FU and drops its iss_ready; flush kills in-flight ops.
// Optional per-FU perf counters are enabled with `define ALU_PERF_CNT_EN.
module alu_fu_array #(
    parameter int NUM_FU = 3,
    parameter int XLEN   = 32,
    parameter int TAG_W  = 6,
    parameter int LAT    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NUM_FU-1:0]       iss_valid,
    output logic [NUM_FU-1:0]       iss_ready,
    input  logic [NUM_FU*4-1:0]     iss_op,
    input  logic [NUM_FU*XLEN-1:0]  iss_src1,
    input  logic [NUM_FU*XLEN-1:0]  iss_src2,
    input  logic [NUM_FU*TAG_W-1:0] iss_tag,
    output logic [NUM_FU-1:0]       wb_valid,
    input  logic [NUM_FU-1:0]       wb_ready,
    output logic [NUM_FU*XLEN-1:0]  wb_data,
    output logic [NUM_FU*TAG_W-1:0] wb_tag
`ifdef ALU_PERF_CNT_EN
    ,
    output logic [NUM_FU*32-1:0]    perf_ops,
    output logic [NUM_FU*32-1:0]    perf_stall
`endif
);

    localparam int SH_W = $clog2(XLEN);

    for (genvar k = 0; k < NUM_FU; k++) begin : fu
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [3:0]       op;
        logic [TAG_W-1:0] tag_in;
        logic [XLEN-1:0]  res;
        logic             stall;
        logic             adv;
        logic             fire;

        assign a      = iss_src1[k*XLEN +: XLEN];
        assign b      = iss_src2[k*XLEN +: XLEN];
        assign op     = iss_op[k*4 +: 4];
        assign tag_in = iss_tag[k*TAG_W +: TAG_W];

        // The whole FU moves as one shift register: no bubble collapsing, no skid.
        assign stall        = stg[LAT-1].v && !wb_ready[k];
        assign adv          = !stall;
        assign fire         = iss_valid[k] && adv;
        assign iss_ready[k] = adv;

        always_comb begin
            res = '0;
            case (op)
                4'd0:    res = a + b;
                4'd1:    res = a - b;
                4'd2:    res = a << b[SH_W-1:0];
                4'd3:    res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
                4'd4:    res = {{(XLEN-1){1'b0}}, (a < b)};
                4'd5:    res = a ^ b;
                4'd6:    res = a >> b[SH_W-1:0];
                4'd7:    res = $unsigned($signed(a) >>> b[SH_W-1:0]);
                4'd8:    res = a | b;
                4'd9:    res = a & b;
                4'd10:   res = b;
                default: res = '0;
            endcase
        end

        for (genvar s = 0; s < LAT; s++) begin : stg
            logic             v;
            logic [XLEN-1:0]  d;
            logic [TAG_W-1:0] t;
            logic             v_in;
            logic [XLEN-1:0]  d_in;
            logic [TAG_W-1:0] t_in;

            if (s == 0) begin : g_head
                assign v_in = fire;
                assign d_in = res;
                assign t_in = tag_in;
            end else begin : g_body
                assign v_in = stg[s-1].v;
                assign d_in = stg[s-1].d;
                assign t_in = stg[s-1].t;
            end

            if (s == LAT-1) begin : g_out
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        v <= 1'b0;
                        d <= '0;
                        t <= '0;
                    end else begin
                        if (flush)
                            v <= 1'b0;
                        else if (adv)
                            v <= v_in;
                        if (adv) begin
                            d <= d_in;
                            t <= t_in;
                        end
                    end
                end
            end else begin : g_mid
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)
                        v <= 1'b0;
                    else if (flush)
                        v <= 1'b0;
                    else if (adv)
                        v <= v_in;
                end

                // Payload carries no reset; the valid bit alone qualifies it.
                always_ff @(posedge clk) begin
                    if (adv) begin
                        d <= d_in;
                        t <= t_in;
                    end
                end
            end
        end

        assign wb_valid[k]              = stg[LAT-1].v;
        assign wb_data[k*XLEN +: XLEN]  = stg[LAT-1].d;
        assign wb_tag[k*TAG_W +: TAG_W] = stg[LAT-1].t;

`ifdef ALU_PERF_CNT_EN
        logic [31:0] ops_cnt;
        logic [31:0] stall_cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ops_cnt   <= '0;
                stall_cnt <= '0;
            end else begin
                if (wb_valid[k] && wb_ready[k])
                    ops_cnt <= ops_cnt + 32'd1;
                if (stall)
                    stall_cnt <= stall_cnt + 32'd1;
            end
        end

        assign perf_ops[k*32 +: 32]   = ops_cnt;
        assign perf_stall[k*32 +: 32] = stall_cnt;
`endif
    end

endmodule

// File: tb/tb_alu_fu_array.sv
// Directed bench for alu_fu_array: one LAT=1 instance (function/throughput) and one LAT=3 instance
// (backpressure, flush, async reset, optional perf counters).
module tb_alu_fu_array;

    localparam int N = 3;
    localparam int X = 32;
    localparam int T = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    logic [N-1:0]   v1, ir1, wv1, rdy1;
    logic [N*4-1:0] op1;
    logic [N*X-1:0] a1, b1, wd1;
    logic [N*T-1:0] tg1, wt1;

    logic [N-1:0]   v3, ir3, wv3, rdy3;
    logic [N*4-1:0] op3;
    logic [N*X-1:0] a3, b3, wd3;
    logic [N*T-1:0] tg3, wt3;

`ifdef ALU_PERF_CNT_EN
    logic [N*32-1:0] po1, ps1, po3, ps3;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_fu_array #(.NUM_FU(N), .XLEN(X), .TAG_W(T), .LAT(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush),
        .iss_valid(v1), .iss_ready(ir1), .iss_op(op1),
        .iss_src1(a1), .iss_src2(b1), .iss_tag(tg1),
        .wb_valid(wv1), .wb_ready(rdy1), .wb_data(wd1), .wb_tag(wt1)
`ifdef ALU_PERF_CNT_EN
        , .perf_ops(po1), .perf_stall(ps1)
`endif
    );

    alu_fu_array #(.NUM_FU(N), .XLEN(X), .TAG_W(T), .LAT(3)) u3 (
        .clk(clk), .rst(rst), .flush(flush),
        .iss_valid(v3), .iss_ready(ir3), .iss_op(op3),
        .iss_src1(a3), .iss_src2(b3), .iss_tag(tg3),
        .wb_valid(wv3), .wb_ready(rdy3), .wb_data(wd3), .wb_tag(wt3)
`ifdef ALU_PERF_CNT_EN
        , .perf_ops(po3), .perf_stall(ps3)
`endif
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv1(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] tg);
        op1[k*4 +: 4] = op;
        a1[k*X +: X]  = a;
        b1[k*X +: X]  = b;
        tg1[k*T +: T] = tg;
    endtask

    task automatic drv3(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] tg);
        op3[k*4 +: 4] = op;
        a3[k*X +: X]  = a;
        b3[k*X +: X]  = b;
        tg3[k*T +: T] = tg;
    endtask

    // Directed vectors for FU0 of the LAT=1 instance: op, src1, src2, expected result.
    logic [3:0]  vop [12];
    logic [31:0] va  [12];
    logic [31:0] vb  [12];
    logic [31:0] vr  [12];

    initial begin
        vop[0]  = 4'd1;  va[0]  = 32'd3;        vb[0]  = 32'd5;        vr[0]  = 32'hFFFF_FFFE;
        vop[1]  = 4'd2;  va[1]  = 32'd1;        vb[1]  = 32'd33;       vr[1]  = 32'd2;
        vop[2]  = 4'd2;  va[2]  = 32'd1;        vb[2]  = 32'd31;       vr[2]  = 32'h8000_0000;
        vop[3]  = 4'd3;  va[3]  = 32'hFFFF_FFFF; vb[3] = 32'd1;        vr[3]  = 32'd1;
        vop[4]  = 4'd4;  va[4]  = 32'hFFFF_FFFF; vb[4] = 32'd1;        vr[4]  = 32'd0;
        vop[5]  = 4'd5;  va[5]  = 32'hF0F0_1234; vb[5] = 32'h0FF0_FFFF; vr[5] = 32'hFF00_EDCB;
        vop[6]  = 4'd6;  va[6]  = 32'h8000_0000; vb[6] = 32'd4;        vr[6]  = 32'h0800_0000;
        vop[7]  = 4'd7;  va[7]  = 32'h7000_0000; vb[7] = 32'd4;        vr[7]  = 32'h0700_0000;
        vop[8]  = 4'd8;  va[8]  = 32'hA000_0005; vb[8] = 32'h0500_0050; vr[8] = 32'hA500_0055;
        vop[9]  = 4'd9;  va[9]  = 32'hFF00_FF00; vb[9] = 32'h0FF0_0FF0; vr[9] = 32'h0F00_0F00;
        vop[10] = 4'd10; va[10] = 32'h1234_5678; vb[10] = 32'hABCD_E000; vr[10] = 32'hABCD_E000;
        vop[11] = 4'd12; va[11] = 32'h1234_5678; vb[11] = 32'h1111_1111; vr[11] = 32'd0;

        v1 = '0; rdy1 = '1; op1 = '0; a1 = '0; b1 = '0; tg1 = '0;
        v3 = '0; rdy3 = '1; op3 = '0; a3 = '0; b3 = '0; tg3 = '0;

        // Reset state
        #2;
        chk("rst_wv1", 64'(wv1), 64'd0);
        chk("rst_wd1", 64'(wd1[31:0]), 64'd0);
        chk("rst_wt1", 64'(wt1), 64'd0);
        chk("rst_wv3", 64'(wv3), 64'd0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("ready_after_rst", 64'({ir1, ir3}), 64'h3F);

        // ADD wraps to 0 on FU0, tag 5, one-cycle latency
        drv1(0, 4'd0, 32'hFFFF_FFFF, 32'd1, 6'd5);
        v1 = 3'b001;
        step();
        chk("add_wrap_vld", 64'(wv1), 64'b001);
        chk("add_wrap_dat", 64'(wd1[31:0]), 64'd0);
        chk("add_wrap_tag", 64'(wt1[5:0]), 64'd5);

        // FU1 SRA and FU2 SLTU in the same cycle
        drv1(1, 4'd7, 32'h8000_0000, 32'd4, 6'd17);
        drv1(2, 4'd4, 32'd1, 32'd2, 6'd33);
        v1 = 3'b110;
        step();
        chk("par_vld", 64'(wv1), 64'b110);
        chk("sra_dat", 64'(wd1[63:32]), 64'hF800_0000);
        chk("sra_tag", 64'(wt1[11:6]), 64'd17);
        chk("sltu_dat", 64'(wd1[95:64]), 64'd1);
        chk("sltu_tag", 64'(wt1[17:12]), 64'd33);

        // Back-to-back op table on FU0 at full throughput
        v1 = 3'b001;
        for (int i = 0; i < 12; i++) begin
            drv1(0, vop[i], va[i], vb[i], 6'(i + 40));
            step();
            chk($sformatf("vec%0d_vld", i), 64'(wv1), 64'b001);
            chk($sformatf("vec%0d_dat", i), 64'(wd1[31:0]), 64'(vr[i]));
            chk($sformatf("vec%0d_tag", i), 64'(wt1[5:0]), 64'(i + 40));
        end
        v1 = '0;
        step();
        chk("idle_vld", 64'(wv1), 64'd0);

        // LAT=3 backpressure: four back-to-back ops into a blocked FU0
        rdy3 = 3'b110;
        v3 = 3'b001;
        for (int i = 0; i < 3; i++) begin
            drv3(0, 4'd0, 32'(100 + i), 32'(i), 6'(10 + i));
            #1;
            chk($sformatf("bp_accept%0d", i), 64'(ir3[0]), 64'd1);
            step();
        end
        chk("bp_vld", 64'(wv3[0]), 64'd1);
        chk("bp_ready_low", 64'(ir3[0]), 64'd0);
        drv3(0, 4'd0, 32'd103, 32'd3, 6'd13);
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("bp_hold_dat%0d", i), 64'(wd3[31:0]), 64'd100);
            chk($sformatf("bp_hold_tag%0d", i), 64'(wt3[5:0]), 64'd10);
            chk($sformatf("bp_hold_rdy%0d", i), 64'(ir3[0]), 64'd0);
        end
        rdy3 = 3'b111;
        step();
        v3 = '0;
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("drain%0d_vld", i), 64'(wv3[0]), 64'd1);
            chk($sformatf("drain%0d_dat", i), 64'(wd3[31:0]), 64'(100 + 2 * i));
            chk($sformatf("drain%0d_tag", i), 64'(wt3[5:0]), 64'(10 + i));
            step();
        end
        chk("drain_empty", 64'(wv3[0]), 64'd0);

        // Flush with two ops in flight and a third firing
        v3 = 3'b001;
        drv3(0, 4'd0, 32'd1, 32'd1, 6'd20);
        step();
        drv3(0, 4'd0, 32'd2, 32'd2, 6'd21);
        step();
        drv3(0, 4'd0, 32'd3, 32'd3, 6'd22);
        flush = 1'b1;
        #1;
        chk("flush_fire_rdy", 64'(ir3[0]), 64'd1);
        step();
        flush = 1'b0;
        v3 = '0;
        chk("flush_ready", 64'(ir3), 64'b111);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("flush_novld%0d", i), 64'(wv3), 64'd0);
            step();
        end

        // Async reset with a held result in the LAT=3 output stage
        rdy3 = 3'b110;
        v3 = 3'b001;
        drv3(0, 4'd0, 32'h1234, 32'h1111, 6'h2A);
        step();
        v3 = '0;
        step();
        step();
        chk("pre_rst_dat", 64'(wd3[31:0]), 64'h2345);
        chk("pre_rst_tag", 64'(wt3[5:0]), 64'h2A);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_vld", 64'({wv1, wv3}), 64'd0);
        chk("arst_dat", 64'(wd3[31:0]), 64'd0);
        chk("arst_tag", 64'(wt3[5:0]), 64'd0);
        #1;
        rst = 1'b0;
        rdy3 = 3'b111;
        step();
        chk("post_rst_ready", 64'(ir3), 64'b111);
        drv3(0, 4'd0, 32'd7, 32'd8, 6'd3);
        v3 = 3'b001;
        step();
        v3 = '0;
        chk("post_rst_t1", 64'(wv3[0]), 64'd0);
        step();
        chk("post_rst_t2", 64'(wv3[0]), 64'd0);
        step();
        chk("post_rst_vld", 64'(wv3[0]), 64'd1);
        chk("post_rst_dat", 64'(wd3[31:0]), 64'd15);
        chk("post_rst_tag", 64'(wt3[5:0]), 64'd3);
        step();

`ifdef ALU_PERF_CNT_EN
        // Ten ops on FU2 with three stall cycles, then a flush
        begin
            int issued;
            issued = 0;
            for (int c = 0; c < 20; c++) begin
                rdy3[2] = !(c >= 5 && c < 8);
                v3[2] = (issued < 10);
                drv3(2, 4'd0, 32'(c), 32'd1, 6'(c));
                #1;
                if (v3[2] && ir3[2])
                    issued++;
                step();
            end
            v3 = '0;
            rdy3 = 3'b111;
        end
        chk("perf_ops2", 64'(po3[95:64]), 64'd10);
        chk("perf_stall2", 64'(ps3[95:64]), 64'd3);
        chk("perf_ops0", 64'(po3[31:0]), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("perf_ops2_flush", 64'(po3[95:64]), 64'd10);
        chk("perf_stall2_flush", 64'(ps3[95:64]), 64'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
